ag6502_int_ctrl: RTL and testbench
==================================

AG6502_INT_CTRL -- requirements
Module: ag6502_int_ctrl

Interface
REQ-001 Parameter NCH, default 8, meaning number of interrupt channels, legal range 1..8.
REQ-002 Parameter VEC_BASE, default 16'hFFE0, meaning vector address of channel 0; channel k uses VEC_BASE + 2*k.
REQ-003 Parameter EDGE_INIT, default 8'hFF, meaning reset value of the mode register (1 = edge, 0 = level), bits above NCH-1 ignored.
REQ-004 phi_0  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 int_in  input  NCH  interrupt requests, active-low, asynchronous to phi_0.
REQ-007 cs  input  1  register select.
REQ-008 read  input  1  1 = read cycle, 0 = write cycle (same polarity as the CPU read pin).
REQ-009 addr  input  2  register index.
REQ-010 db_in  input  8  write data.
REQ-011 db_out  output  8  read data, combinational from registers.
REQ-012 irq  output  1  interrupt request to CPU, active-low, registered.
REQ-013 vec  output  16  vector address of the highest-priority active channel, combinational.

Function
REQ-014 Each int_in bit SHALL pass a two-flop synchronizer; edge detect uses a third flop holding the previous synchronized level.
REQ-015 Edge mode: pending[k] SHALL set on a synchronized high-to-low transition and hold until cleared.
REQ-016 Level mode: pending[k] SHALL equal the inverted synchronized input every cycle; writes and acks have no effect on it.
REQ-017 active = pending & mask; irq register SHALL load ~(|active) every cycle.
REQ-018 Latency: int_in low before edge 0 -> pending set after edge 2 -> irq low after edge 3 (sampled by the 4th edge counting edge 0 as 1st).
REQ-019 Priority fixed: lowest active index wins; id = that index; if none active, id = 0 and vec = VEC_BASE.
REQ-020 Register map: 0 = pending (R; W1C, edge channels only); 1 = mask (R/W, 1 = enabled); 2 = mode (R/W); 3 = R: {active-flag, 4'b0, id[2:0]}, W: ack.
REQ-021 Reading addr 3 with a channel active SHALL act as ack: clears pending[id] if id is in edge mode.
REQ-022 Write to addr 3 (any data) SHALL also ack, the same as REQ-021.
REQ-023 Simultaneous set (new edge) and clear (W1C or ack) on the same bit in one cycle: set SHALL win.
REQ-024 Mode change edge->level SHALL take effect on the next edge; level->edge SHALL clear pending[k] and arm the edge detector from the current synchronized level (no spurious edge).
REQ-025 Masked pending bits SHALL stay latched and raise irq once unmasked, 1 edge later.
REQ-026 Unused bits (>= NCH) SHALL read 0 and ignore writes.

Reset
REQ-027 While rst is low: sync and edge-detect flops = 1 (inactive), pending = 0, mask = 0, mode = EDGE_INIT, irq = 1.
REQ-028 Reset asserted mid-operation SHALL clear pending state at once; a line held low across reset release SHALL NOT produce an edge event.

Structure
REQ-029 Register address constants and the default VEC_BASE SHALL live in a shared package/include used by the 6502 system top.
REQ-030 One sub-module ag6502_int_chan (synchronizer, edge detect, pending bit for one channel) SHALL be instantiated NCH times with a generate loop; priority encode and register file stay in the top.

Verification
REQ-031 Edge: mask=01, mode=01, int_in[0] pulses low 1 cycle -> irq low 4 edges later; read addr 3 = 8'h80, vec=FFE0; after ack irq returns high 1 edge later.
REQ-032 Priority: mask=FF, channels 5 and 2 fall together -> id=2, vec=FFE4; ack -> id=5, vec=FFEA; second ack -> irq high.
REQ-033 Level: mode=00, mask=08, int_in[3] held low -> irq low; W1C 08 to addr 0 -> pending stays 1; release input -> irq high 3 edges later.
REQ-034 Collision: W1C on bit 1 in the same cycle as a new edge on channel 1 -> pending[1] stays 1.
REQ-035 Reset: assert rst with pending=FF, irq low -> all outputs at reset values immediately; release with int_in[0] held low -> no pending.
REQ-036 Param: NCH=3, VEC_BASE=16'hFFF0 -> mask write FF reads back 07; channel 2 -> vec=FFF4.

Source files
------------

// File: rtl/ag6502_int_ctrl_pkg.sv
// rtl/ag6502_int_ctrl_pkg.sv - shared register map, default vector base and priority helper
package ag6502_int_ctrl_pkg;

  localparam logic [1:0]  REG_PEND = 2'd0;
  localparam logic [1:0]  REG_MASK = 2'd1;
  localparam logic [1:0]  REG_MODE = 2'd2;
  localparam logic [1:0]  REG_STAT = 2'd3;

  localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFFE0;
  localparam int          MAX_CH           = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] id;
  } prio_t;

  // Lowest set index wins; id stays 0 when nothing is set.
  function automatic prio_t prio_lowest(input logic [MAX_CH-1:0] act);
    prio_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (act[i]) begin
        r.found = 1'b1;
        r.id    = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ag6502_int_chan.sv
// rtl/ag6502_int_chan.sv - one interrupt channel: synchronizer, edge detect, pending bit
module ag6502_int_chan (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic int_ni,
  input  logic edge_mode_i,
  input  logic to_edge_i,
  input  logic arm_i,
  input  logic clr_i,
  output logic pend_o
);

  logic s1_q, s2_q, prev_q, pend_q;
  logic pend_d, fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      s1_q   <= int_ni;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    fall = arm_i & prev_q & ~s2_q;
    if (!edge_mode_i) begin
      // Switching to edge mode drops the level-derived bit; prev_q already tracks the line.
      pend_d = to_edge_i ? 1'b0 : ~s2_q;
    end else begin
      pend_d = fall | (pend_q & ~clr_i);
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/ag6502_int_ctrl.sv
// rtl/ag6502_int_ctrl.sv - 6502 interrupt controller top: channels, register file, priority encode
module ag6502_int_ctrl
  import ag6502_int_ctrl_pkg::*;
#(
  parameter int          NCH       = 8,
  parameter logic [15:0] VEC_BASE  = VEC_BASE_DEFAULT,
  parameter logic [7:0]  EDGE_INIT = 8'hFF
) (
  input  logic           phi_0,
  input  logic           rst,
  input  logic [NCH-1:0] int_in,
  input  logic           cs,
  input  logic           read,
  input  logic [1:0]     addr,
  input  logic [7:0]     db_in,
  output logic [7:0]     db_out,
  output logic           irq,
  output logic [15:0]    vec
);

  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] mode_q, mode_d;
  logic           irq_q;
  logic [1:0]     arm_cnt_q;
  logic           arm;

  logic [NCH-1:0] pending, active, w1c, ack_oh, clr, to_edge;
  logic [7:0]     act8;
  logic           wr, ack;
  prio_t          pr;

  assign wr = cs & ~read;

  always_comb begin
    act8           = '0;
    act8[NCH-1:0]  = active;
  end

  assign active = pending & mask_q;
  assign pr     = prio_lowest(act8);
  assign ack    = cs && (addr == REG_STAT) && pr.found;

  always_comb begin
    w1c    = '0;
    ack_oh = '0;
    if (wr && (addr == REG_PEND)) w1c = db_in[NCH-1:0] & mode_q;
    for (int k = 0; k < NCH; k++) ack_oh[k] = ack && (pr.id == 3'(k));
  end

  assign clr = w1c | ack_oh;

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr && (addr == REG_MASK)) mask_d = db_in[NCH-1:0];
    if (wr && (addr == REG_MODE)) mode_d = db_in[NCH-1:0];
  end

  assign to_edge = ~mode_q & mode_d;

  // Fall detection stays off until the synchronizers and prev flop hold
  // post-reset samples, so a line held low across release is not an edge.
  assign arm = &arm_cnt_q;

  always_ff @(posedge phi_0 or negedge rst) begin
    if (!rst) begin
      mask_q    <= '0;
      mode_q    <= EDGE_INIT[NCH-1:0];
      irq_q     <= 1'b1;
      arm_cnt_q <= 2'd0;
    end else begin
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      irq_q     <= ~(|active);
      arm_cnt_q <= arm ? arm_cnt_q : arm_cnt_q + 2'd1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    ag6502_int_chan u_chan (
      .clk_i       (phi_0),
      .rst_ni      (rst),
      .int_ni      (int_in[k]),
      .edge_mode_i (mode_q[k]),
      .to_edge_i   (to_edge[k]),
      .arm_i       (arm),
      .clr_i       (clr[k]),
      .pend_o      (pending[k])
    );
  end

  always_comb begin
    db_out = '0;
    case (addr)
      REG_PEND: db_out[NCH-1:0] = pending;
      REG_MASK: db_out[NCH-1:0] = mask_q;
      REG_MODE: db_out[NCH-1:0] = mode_q;
      default:  db_out = {pr.found, 4'b0000, pr.id};
    endcase
  end

  assign irq = irq_q;
  assign vec = VEC_BASE + {12'h000, pr.id, 1'b0};

endmodule

// File: tb/tb_ag6502_int_ctrl.sv
// tb/tb_ag6502_int_ctrl.sv - directed scoreboard bench for ag6502_int_ctrl (default and NCH=3 instances)
module tb_ag6502_int_ctrl;

  logic        phi_0 = 1'b0;
  logic        rst   = 1'b0;
  logic [7:0]  int_in = 8'hFF;
  logic        cs    = 1'b0;
  logic        read  = 1'b1;
  logic [1:0]  addr  = 2'd0;
  logic [7:0]  db_in = 8'h00;
  logic [7:0]  db_out, p_db_out;
  logic        irq, p_irq;
  logic [15:0] vec, p_vec;

  always #5 phi_0 = ~phi_0;

  ag6502_int_ctrl dut (
    .phi_0(phi_0), .rst(rst), .int_in(int_in), .cs(cs), .read(read),
    .addr(addr), .db_in(db_in), .db_out(db_out), .irq(irq), .vec(vec)
  );

  ag6502_int_ctrl #(.NCH(3), .VEC_BASE(16'hFFF0)) dut_p (
    .phi_0(phi_0), .rst(rst), .int_in(int_in[2:0]), .cs(cs), .read(read),
    .addr(addr), .db_in(db_in), .db_out(p_db_out), .irq(p_irq), .vec(p_vec)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] d, pd;

  task automatic exp_v(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge phi_0);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    cs = 1'b1; read = 1'b0; addr = a; db_in = v;
    tick();
    cs = 1'b0; read = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v, output logic [7:0] pv);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    v = db_out;
    pv = p_db_out;
    tick();
    cs = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] v, output logic [7:0] pv);
    addr = a;
    #1;
    v = db_out;
    pv = p_db_out;
  endtask

  task automatic pulse(input logic [7:0] lines);
    int_in = lines;
    tick();
    int_in = 8'hFF;
  endtask

  initial begin
    #12 rst = 1'b1;
    ticks(4);

    // reset state
    exp_v("rst_irq", 16'h1);      check(irq);
    exp_v("rst_vec", 16'hFFE0);   check(vec);
    exp_v("rst_pend", 16'h00);    peek(2'd0, d, pd); check(d);
    exp_v("rst_mask", 16'h00);    peek(2'd1, d, pd); check(d);
    exp_v("rst_mode", 16'hFF);    peek(2'd2, d, pd); check(d);
    exp_v("rst_stat", 16'h00);    peek(2'd3, d, pd); check(d);
    exp_v("rst_p_mode", 16'h07);  peek(2'd2, d, pd); check(pd);

    // single edge channel, latency and ack by read
    bus_write(2'd1, 8'h01);
    bus_write(2'd2, 8'h01);
    exp_v("e_pend_edge2", 16'h01);
    exp_v("e_irq_edge2", 16'h1);
    exp_v("e_irq_edge3", 16'h0);
    pulse(8'hFE);
    ticks(2);
    peek(2'd0, d, pd); check(d);
    check(irq);
    tick();
    check(irq);
    exp_v("e_vec", 16'hFFE0);     check(vec);
    exp_v("e_stat", 16'h80);      bus_read(2'd3, d, pd); check(d);
    exp_v("e_ack_pend", 16'h00);  peek(2'd0, d, pd); check(d);
    exp_v("e_irq_ack0", 16'h0);   check(irq);
    exp_v("e_irq_ack1", 16'h1);   tick(); check(irq);

    // priority, write-ack then read-ack
    bus_write(2'd1, 8'hFF);
    bus_write(2'd2, 8'hFF);
    pulse(8'hDB);
    ticks(3);
    exp_v("p_irq", 16'h0);        check(irq);
    exp_v("p_vec2", 16'hFFE4);    check(vec);
    exp_v("p_stat2", 16'h82);     peek(2'd3, d, pd); check(d);
    bus_write(2'd3, 8'h00);
    exp_v("p_vec5", 16'hFFEA);    check(vec);
    exp_v("p_stat5", 16'h85);     bus_read(2'd3, d, pd); check(d);
    exp_v("p_irq_ack", 16'h1);    tick(); check(irq);

    // masked pending latches, irq one edge after unmask
    bus_write(2'd1, 8'h00);
    pulse(8'hEF);
    ticks(4);
    exp_v("m_irq_masked", 16'h1); check(irq);
    exp_v("m_pend", 16'h10);      peek(2'd0, d, pd); check(d);
    bus_write(2'd1, 8'h10);
    exp_v("m_irq_unmask0", 16'h1); check(irq);
    exp_v("m_irq_unmask1", 16'h0); tick(); check(irq);
    bus_write(2'd3, 8'h00);
    exp_v("m_irq_clear", 16'h1);  tick(); check(irq);

    // level mode: W1C ignored, follows input
    bus_write(2'd2, 8'h00);
    bus_write(2'd1, 8'h08);
    int_in = 8'hF7;
    ticks(4);
    exp_v("l_irq_low", 16'h0);    check(irq);
    bus_write(2'd0, 8'h08);
    exp_v("l_w1c_pend", 16'h08);  peek(2'd0, d, pd); check(d);
    int_in = 8'hFF;
    ticks(3);
    exp_v("l_pend_rel", 16'h00);  peek(2'd0, d, pd); check(d);
    exp_v("l_irq_rel", 16'h1);    tick(); check(irq);

    // level->edge with line held low: cleared, no spurious edge
    int_in = 8'hF7;
    ticks(4);
    exp_v("le_pend_level", 16'h08); peek(2'd0, d, pd); check(d);
    bus_write(2'd2, 8'hFF);
    exp_v("le_pend_switch", 16'h00); peek(2'd0, d, pd); check(d);
    ticks(3);
    exp_v("le_pend_later", 16'h00);  peek(2'd0, d, pd); check(d);
    exp_v("le_irq_later", 16'h1);    check(irq);
    int_in = 8'hFF;
    ticks(4);

    // W1C alone clears; W1C colliding with a new edge keeps the bit
    bus_write(2'd1, 8'h02);
    pulse(8'hFD);
    ticks(3);
    exp_v("c_pend_set", 16'h02);  peek(2'd0, d, pd); check(d);
    bus_write(2'd0, 8'h02);
    exp_v("c_w1c_clear", 16'h00); peek(2'd0, d, pd); check(d);
    pulse(8'hFD);
    tick();
    bus_write(2'd0, 8'h02);
    exp_v("c_collide", 16'h02);   peek(2'd0, d, pd); check(d);
    ticks(3);
    bus_write(2'd0, 8'h02);
    exp_v("c_final_clear", 16'h00); peek(2'd0, d, pd); check(d);
    exp_v("c_irq_high", 16'h1);   tick(); check(irq);

    // reset mid-operation, line held low across release
    bus_write(2'd1, 8'hFF);
    pulse(8'h00);
    ticks(4);
    exp_v("r_irq_pre", 16'h0);    check(irq);
    exp_v("r_pend_pre", 16'hFF);  peek(2'd0, d, pd); check(d);
    #2 rst = 1'b0;
    #1;
    exp_v("r_irq", 16'h1);        check(irq);
    exp_v("r_vec", 16'hFFE0);     check(vec);
    exp_v("r_pend", 16'h00);      peek(2'd0, d, pd); check(d);
    exp_v("r_mask", 16'h00);      peek(2'd1, d, pd); check(d);
    exp_v("r_mode", 16'hFF);      peek(2'd2, d, pd); check(d);
    int_in = 8'hFE;
    @(negedge phi_0);
    rst = 1'b1;
    tick();
    bus_write(2'd1, 8'h01);
    ticks(6);
    exp_v("r_held_pend", 16'h00); peek(2'd0, d, pd); check(d);
    exp_v("r_held_irq", 16'h1);   check(irq);
    int_in = 8'hFF;
    ticks(3);

    // narrow instance: unused bits and vector base
    bus_write(2'd1, 8'hFF);
    exp_v("n_mask_rb", 16'h07);   peek(2'd1, d, pd); check(pd);
    pulse(8'hFB);
    ticks(4);
    exp_v("n_p_vec", 16'hFFF4);   check(p_vec);
    exp_v("n_vec", 16'hFFE4);     check(vec);
    exp_v("n_p_stat", 16'h82);    peek(2'd3, d, pd); check(pd);
    exp_v("n_p_irq", 16'h0);      check(p_irq);
    exp_v("n_p_pend", 16'h04);    peek(2'd0, d, pd); check(pd);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
